// File: rtl/leve1_axir_arb.sv
// Two-requester (instruction fetch / data load) arbiter onto one single-beat AXI read slave.
// One transaction in flight at a time; round-robin on simultaneous requests.
module leve1_axir_arb #(
  parameter int XLEN    = 32,
  parameter int RRESP_W = 2
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [XLEN-1:0]    I_ARADDR,
  input  logic               I_ARVALID,
  output logic               I_ARREADY,
  output logic [XLEN-1:0]    I_RDATA,
  output logic [RRESP_W-1:0] I_RRESP,
  output logic               I_RVALID,
  input  logic               I_RREADY,
  input  logic [XLEN-1:0]    D_ARADDR,
  input  logic               D_ARVALID,
  output logic               D_ARREADY,
  output logic [XLEN-1:0]    D_RDATA,
  output logic [RRESP_W-1:0] D_RRESP,
  output logic               D_RVALID,
  input  logic               D_RREADY,
  output logic [XLEN-1:0]    M_ARADDR,
  output logic               M_ARVALID,
  input  logic               M_ARREADY,
  input  logic [XLEN-1:0]    M_RDATA,
  input  logic [RRESP_W-1:0] M_RRESP,
  input  logic               M_RVALID,
  output logic               M_RREADY,
  output logic [1:0]         OWNER
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  logic [1:0]      state_r;
  logic [1:0]      owner_r;
  logic            last_d_r;
  logic [XLEN-1:0] addr_r;
  logic            grant_i_s;
  logic            grant_d_s;
  logic            in_data_s;
  logic            rready_s;
  logic            r_hs_s;

  // Grant selection in IDLE; on a collision the requester that did not go last wins.
  // Gated by RSTn so no ready is presented while reset is held.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if ((state_r == ST_IDLE) && RSTn) begin
      if (I_ARVALID && D_ARVALID) begin
        grant_i_s = last_d_r;
        grant_d_s = ~last_d_r;
      end else begin
        grant_i_s = I_ARVALID;
        grant_d_s = D_ARVALID;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  assign in_data_s = (state_r == ST_DATA);
  assign rready_s  = (owner_r[0] & I_RREADY) | (owner_r[1] & D_RREADY);
  assign r_hs_s    = in_data_s & M_RVALID & rready_s;

  assign I_ARREADY = grant_i_s;
  assign D_ARREADY = grant_d_s;
  assign M_ARVALID = (state_r == ST_ADDR);
  assign M_ARADDR  = addr_r;
  assign M_RREADY  = in_data_s & rready_s;
  assign I_RVALID  = in_data_s & owner_r[0] & M_RVALID;
  assign D_RVALID  = in_data_s & owner_r[1] & M_RVALID;
  // Read data and response pass through untouched; only RVALID steers the beat.
  assign I_RDATA   = M_RDATA;
  assign D_RDATA   = M_RDATA;
  assign I_RRESP   = M_RRESP;
  assign D_RRESP   = M_RRESP;
  assign OWNER     = owner_r;

  // Transaction sequencing: capture the winner, issue the address, forward the single beat.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r  <= ST_IDLE;
      owner_r  <= 2'b00;
      last_d_r <= 1'b1;
      addr_r   <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_i_s) begin
            addr_r  <= I_ARADDR;
            owner_r <= 2'b01;
            state_r <= ST_ADDR;
          end else if (grant_d_s) begin
            addr_r  <= D_ARADDR;
            owner_r <= 2'b10;
            state_r <= ST_ADDR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (M_ARREADY) begin
            state_r <= ST_DATA;
          end else begin
            state_r <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (r_hs_s) begin
            last_d_r <= owner_r[1];
            owner_r  <= 2'b00;
            state_r  <= ST_IDLE;
          end else begin
            state_r <= ST_DATA;
          end
        end
        default: begin
          owner_r <= 2'b00;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/leve1_axir_arb.md
LEVE1_AXIR_ARB -- requirements
Module: leve1_axir_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter RRESP_W, default 2, read-response width.
REQ-003 SHALL use one clock and an asynchronous active-low reset; all state SHALL clear on RSTn low regardless of CLK.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RSTn  in  1  reset, asynchronous, active-low.
REQ-006 I_ARADDR  in  XLEN  instruction-fetch read address.
REQ-007 I_ARVALID  in  1 / I_ARREADY  out  1  instruction address handshake.
REQ-008 I_RDATA  out  XLEN / I_RRESP  out  RRESP_W / I_RVALID  out  1 / I_RREADY  in  1  instruction read-data channel.
REQ-009 D_ARADDR, D_ARVALID, D_ARREADY, D_RDATA, D_RRESP, D_RVALID, D_RREADY SHALL mirror REQ-006..008 for the data-load requester.
REQ-010 M_ARADDR  out  XLEN / M_ARVALID  out  1 / M_ARREADY  in  1  shared slave address channel.
REQ-011 M_RDATA  in  XLEN / M_RRESP  in  RRESP_W / M_RVALID  in  1 / M_RREADY  out  1  shared slave read-data channel.
REQ-012 OWNER  out  2  one-hot current owner, bit0 = I, bit1 = D, 2'b00 when idle.

Function
REQ-013 SHALL support single-beat reads only, one outstanding transaction total.
REQ-014 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE.
REQ-015 In IDLE, a requester with ARVALID=1 SHALL win if it is the only requester.
REQ-016 If both ARVALID=1 in IDLE, the requester not equal to LAST SHALL win (round-robin).
REQ-017 LAST SHALL reset to D, so I wins the first collision after reset.
REQ-018 In IDLE, the winner's ARREADY SHALL be 1 combinationally in the same cycle; the loser's ARREADY SHALL be 0.
REQ-019 On the winner's handshake, the block SHALL register the address and owner, and SHALL enter ADDR on the next edge.
REQ-020 In ADDR, M_ARVALID SHALL be 1 and M_ARADDR SHALL be the registered address, held stable until M_ARREADY=1.
REQ-021 On M_ARVALID & M_ARREADY, the block SHALL enter DATA.
REQ-022 Outside ADDR, M_ARVALID SHALL be 0.
REQ-023 In DATA, the owner's RVALID SHALL equal M_RVALID, and M_RREADY SHALL equal the owner's RREADY, both combinationally.
REQ-024 The non-owner's RVALID SHALL be 0 at all times.
REQ-025 I_RDATA/D_RDATA SHALL equal M_RDATA, and I_RRESP/D_RRESP SHALL equal M_RRESP, unmodified (error responses pass through).
REQ-026 On M_RVALID & M_RREADY in DATA, the block SHALL set LAST to the owner, return to IDLE, and clear OWNER.
REQ-027 Outside DATA, M_RREADY SHALL be 0 and both RVALID outputs SHALL be 0; M_RVALID outside DATA SHALL be ignored.
REQ-028 Both ARREADY outputs SHALL be 0 in ADDR and DATA; a pending request SHALL wait without loss.
REQ-029 A new grant SHALL NOT be issued in the same cycle as a completion; the earliest next grant is the following IDLE cycle.
REQ-030 With a zero-wait slave, each transaction SHALL take 3 cycles, giving a throughput of 1 read per 3 cycles.
REQ-031 The owner dropping ARVALID after its handshake SHALL NOT affect the transaction in flight.

Reset
REQ-032 On RSTn low: state=IDLE, LAST=D, OWNER=0, M_ARVALID=0, M_RREADY=0, I/D_ARREADY=0, I/D_RVALID=0, registered address=0.
REQ-033 Reset asserted in ADDR or DATA SHALL abandon the transaction; after release the FSM SHALL be in IDLE with no response forwarded.

Verification
REQ-034 After reset, I_ARVALID=1 with I_ARADDR=0x100 and a zero-wait slave returning 0xDEADBEEF -> M_ARVALID at cycle 1 with address 0x100; I_RVALID=1 with I_RDATA=0xDEADBEEF at cycle 2; D_RVALID=0 throughout.
REQ-035 I and D both request at cycle 0 after reset, both held -> grants in order I, D, I; OWNER sequence 01, 10, 01.
REQ-036 Slave holds M_ARREADY=0 for 4 cycles -> M_ARADDR stable and M_ARVALID=1 for 5 cycles; D_ARREADY=0 throughout.
REQ-037 D owner with D_RREADY=0 for 3 cycles while M_RVALID=1 -> M_RREADY=0 for those cycles; completion on the first cycle D_RREADY=1.
REQ-038 Slave returns M_RRESP=2'b10 to D -> D_RRESP=2'b10 and the FSM returns to IDLE normally.
REQ-039 RSTn pulsed low in DATA -> all outputs at reset values immediately; next request is granted from IDLE.
